// File: rtl/bus_pkg.sv
// Shared definitions for the CPU bus source arbiter: sizing, source codes and FSM encoding.
package bus_pkg;

    localparam int N_SRC    = 24;
    localparam int SEL_W    = 5;
    localparam int MAX_HOLD = 4;
    localparam int HOLD_W   = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

    typedef enum logic [SEL_W-1:0] {
        SRC_R0  = 5'd0,  SRC_R1  = 5'd1,  SRC_R2  = 5'd2,  SRC_R3  = 5'd3,
        SRC_R4  = 5'd4,  SRC_R5  = 5'd5,  SRC_R6  = 5'd6,  SRC_R7  = 5'd7,
        SRC_R8  = 5'd8,  SRC_R9  = 5'd9,  SRC_R10 = 5'd10, SRC_R11 = 5'd11,
        SRC_R12 = 5'd12, SRC_R13 = 5'd13, SRC_R14 = 5'd14, SRC_R15 = 5'd15,
        SRC_HI  = 5'd16, SRC_LO  = 5'd17, SRC_ZHI = 5'd18, SRC_ZLO = 5'd19,
        SRC_PC  = 5'd20, SRC_MDR = 5'd21, SRC_INPORT = 5'd22, SRC_C = 5'd23
    } src_code_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_GRANT    = 2'd1,
        ST_HANDOVER = 2'd2
    } arb_state_e;

    function automatic logic [N_SRC-1:0] src_onehot(input logic [SEL_W-1:0] idx);
        return {{(N_SRC-1){1'b0}}, 1'b1} << idx;
    endfunction

endpackage

// File: rtl/bus_source_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request after rr_ptr, wrapping modulo N_SRC.
module rr_pick
    import bus_pkg::*;
(
    input  logic [N_SRC-1:0] req,
    input  logic [SEL_W-1:0] rr_ptr,
    output logic             any,
    output logic [SEL_W-1:0] win_idx
);

    logic [SEL_W:0] pos_s;

    // Scan from farthest to nearest so the closest requester after rr_ptr is the last to overwrite
    always_comb begin
        any     = |req;
        win_idx = {SEL_W{1'b0}};
        pos_s   = {(SEL_W+1){1'b0}};
        for (int k = N_SRC; k >= 1; k--) begin
            pos_s   = {1'b0, rr_ptr} + (SEL_W+1)'(k);
            pos_s   = (pos_s >= (SEL_W+1)'(N_SRC)) ? pos_s - (SEL_W+1)'(N_SRC) : pos_s;
            win_idx = req[pos_s[SEL_W-1:0]] ? pos_s[SEL_W-1:0] : win_idx;
        end
    end

endmodule

// File: rtl/bus_source_arbiter.sv
// Round-robin owner arbiter for the 24-source CPU bus with turnaround cycle and hold-time pre-emption.
module bus_source_arbiter
    import bus_pkg::*;
(
    input  logic             clk,
    input  logic             clr_n,
    input  logic [N_SRC-1:0] req,
    input  logic             lock,
    output logic [N_SRC-1:0] grant,
    output logic [SEL_W-1:0] bus_sel,
    output logic             bus_valid,
    output logic             preempt
);

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    arb_state_e        st_r;
    logic [SEL_W-1:0]  winner_r;
    logic [SEL_W-1:0]  rr_ptr_r;
    logic [HOLD_W-1:0] hold_cnt_r;
    logic [N_SRC-1:0]  grant_r;
    logic [SEL_W-1:0]  bus_sel_r;
    logic              bus_valid_r;
    logic              preempt_r;

    logic              any_s;
    logic [SEL_W-1:0]  win_s;
    logic              others_s;

    // rr_ptr already holds the previous owner during HANDOVER, so one picker serves both states
    rr_pick u_pick (
        .req     (req),
        .rr_ptr  (rr_ptr_r),
        .any     (any_s),
        .win_idx (win_s)
    );

    assign others_s = |(req & ~src_onehot(winner_r));

    // Arbitration FSM with all bus-facing outputs registered
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            st_r        <= ST_IDLE;
            winner_r    <= {SEL_W{1'b0}};
            rr_ptr_r    <= SEL_W'(N_SRC - 1);
            hold_cnt_r  <= {HOLD_W{1'b0}};
            grant_r     <= {N_SRC{1'b0}};
            bus_sel_r   <= {SEL_W{1'b0}};
            bus_valid_r <= 1'b0;
            preempt_r   <= 1'b0;
        end else begin
            preempt_r <= 1'b0;
            case (st_r)
                ST_IDLE, ST_HANDOVER: begin
                    hold_cnt_r <= {HOLD_W{1'b0}};
                    if (any_s) begin
                        st_r        <= ST_GRANT;
                        winner_r    <= win_s;
                        grant_r     <= src_onehot(win_s);
                        bus_sel_r   <= win_s;
                        bus_valid_r <= 1'b1;
                    end else begin
                        st_r        <= ST_IDLE;
                        grant_r     <= {N_SRC{1'b0}};
                        bus_sel_r   <= {SEL_W{1'b0}};
                        bus_valid_r <= 1'b0;
                    end
                end
                ST_GRANT: begin
                    // A voluntary release takes precedence over a coincident timeout
                    if (!req[winner_r] || (hold_cnt_r == HOLD_LAST && !lock && others_s)) begin
                        st_r        <= ST_HANDOVER;
                        rr_ptr_r    <= winner_r;
                        hold_cnt_r  <= {HOLD_W{1'b0}};
                        grant_r     <= {N_SRC{1'b0}};
                        bus_sel_r   <= {SEL_W{1'b0}};
                        bus_valid_r <= 1'b0;
                        preempt_r   <= req[winner_r];
                    end else begin
                        st_r       <= ST_GRANT;
                        hold_cnt_r <= (hold_cnt_r == HOLD_LAST) ? hold_cnt_r : hold_cnt_r + HOLD_W'(1);
                    end
                end
                default: begin
                    st_r        <= ST_IDLE;
                    hold_cnt_r  <= {HOLD_W{1'b0}};
                    grant_r     <= {N_SRC{1'b0}};
                    bus_sel_r   <= {SEL_W{1'b0}};
                    bus_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign grant     = grant_r;
    assign bus_sel   = bus_sel_r;
    assign bus_valid = bus_valid_r;
    assign preempt   = preempt_r;

endmodule

// File: tb/tb_bus_source_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic against an owner/hold-time reference model.
module tb_bus_source_arbiter;
    import bus_pkg::*;

    logic             clk = 1'b0;
    logic             clr_n;
    logic [N_SRC-1:0] req;
    logic             lock;
    logic [N_SRC-1:0] grant;
    logic [SEL_W-1:0] bus_sel;
    logic             bus_valid;
    logic             preempt;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: current owner (-1 = none), cycles owned so far, last owner, pre-empt flag
    int m_owner;
    int m_held;
    int m_last;
    bit m_pre;

    always #5 clk = ~clk;

    bus_source_arbiter dut (
        .clk       (clk),
        .clr_n     (clr_n),
        .req       (req),
        .lock      (lock),
        .grant     (grant),
        .bus_sel   (bus_sel),
        .bus_valid (bus_valid),
        .preempt   (preempt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_held  = 0;
        m_last  = N_SRC - 1;
        m_pre   = 1'b0;
    endtask

    task automatic model_edge(input logic [N_SRC-1:0] r, input logic l);
        bit others;
        m_pre = 1'b0;
        if (m_owner >= 0) begin
            others = (r & ~(N_SRC'(1) << m_owner)) != '0;
            if (!r[m_owner]) begin
                m_last  = m_owner;
                m_owner = -1;
            end else if (m_held >= MAX_HOLD && !l && others) begin
                m_last  = m_owner;
                m_owner = -1;
                m_pre   = 1'b1;
            end else begin
                m_held++;
            end
        end else begin
            for (int k = 1; k <= N_SRC; k++) begin
                if (r[(m_last + k) % N_SRC]) begin
                    m_owner = (m_last + k) % N_SRC;
                    m_held  = 1;
                    break;
                end
            end
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".grant"}, 32'(grant), (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
        chk({tag, ".bus_sel"}, 32'(bus_sel), (m_owner >= 0) ? 32'(m_owner) : 32'd0);
        chk({tag, ".bus_valid"}, 32'(bus_valid), 32'(m_owner >= 0));
        chk({tag, ".preempt"}, 32'(preempt), 32'(m_pre));
        chk({tag, ".onehot0"}, 32'($onehot0(grant)), 32'd1);
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_edge(req, lock);
        #1;
        check_outputs(tag);
    endtask

    task automatic do_reset();
        clr_n = 1'b0;
        req   = '0;
        lock  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        clr_n = 1'b1;
        model_reset();
    endtask

    initial begin
        int  exp_idx;
        bit  prev_v;
        logic [N_SRC-1:0] all_ones;
        all_ones = '1;

        // Reset values
        do_reset();
        chk("rst.grant", 32'(grant), 32'd0);
        chk("rst.bus_sel", 32'(bus_sel), 32'd0);
        chk("rst.bus_valid", 32'(bus_valid), 32'd0);
        chk("rst.preempt", 32'(preempt), 32'd0);

        // 1: PC request granted one cycle later
        req = N_SRC'(1) << 20;
        tick("t1");
        chk("t1.pc_grant", 32'(grant), 32'h0010_0000);
        chk("t1.pc_sel", 32'(bus_sel), 32'd20);
        repeat (3) tick("t1hold");

        // 2: R3 and MDR alternate under pre-emption
        do_reset();
        req = (N_SRC'(1) << 3) | (N_SRC'(1) << 21);
        exp_idx = 3;
        prev_v  = 1'b0;
        for (int c = 0; c < 30; c++) begin
            tick("t2");
            if (bus_valid && !prev_v) begin
                chk("t2.alternate", 32'(bus_sel), 32'(exp_idx));
                exp_idx = (exp_idx == 3) ? 21 : 3;
            end
            prev_v = bus_valid;
        end

        // 3: locked ZHI is never pre-empted; unlocking pre-empts in favour of R1
        do_reset();
        req = N_SRC'(1) << 18;
        tick("t3");
        lock = 1'b1;
        req  = req | (N_SRC'(1) << 1);
        repeat (12) tick("t3lock");
        lock = 1'b0;
        tick("t3unlock");
        chk("t3.preempt", 32'(preempt), 32'd1);
        tick("t3gap");
        chk("t3.r1", 32'(grant), 32'd2);

        // 4: all sources requesting are served in index order
        do_reset();
        req = all_ones;
        exp_idx = 0;
        prev_v  = 1'b0;
        for (int c = 0; c < 5 * N_SRC + 4; c++) begin
            tick("t4");
            if (bus_valid && !prev_v) begin
                chk("t4.order", 32'(bus_sel), 32'(exp_idx));
                exp_idx = (exp_idx + 1) % N_SRC;
            end
            prev_v = bus_valid;
        end

        // 5: release coincident with timeout is not a pre-emption
        do_reset();
        req = (N_SRC'(1) << 5) | (N_SRC'(1) << 9);
        repeat (4) tick("t5");
        req = N_SRC'(1) << 9;
        tick("t5drop");
        chk("t5.preempt", 32'(preempt), 32'd0);
        chk("t5.grant", 32'(grant), 32'd0);
        tick("t5next");

        // 6: async reset mid-grant clears outputs between edges and restores pointer
        do_reset();
        req = N_SRC'(1) << 7;
        repeat (2) tick("t6");
        #2;
        clr_n = 1'b0;
        #1;
        chk("t6.async_grant", 32'(grant), 32'd0);
        chk("t6.async_valid", 32'(bus_valid), 32'd0);
        clr_n = 1'b1;
        model_reset();
        #1;
        req = all_ones;
        tick("t6after");
        chk("t6.src0_first", 32'(grant), 32'd1);

        // Random traffic
        do_reset();
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 3) == 0) req = N_SRC'($urandom & $urandom);
            lock = ($urandom_range(0, 9) == 0);
            tick("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
